// File: rtl/icache_refill_responder.sv
// icache_refill_responder: memory-side I-cache refill responder with programmable latency and preloadable word array
module icache_refill_responder #(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 4,
  parameter int BEATS      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [31:0]           req_addr,
  input  logic [7:0]            req_len,
  output logic                  rsp_ready,
  output logic [63:0]           rsp_data,
  output logic                  rsp_last,
  input  logic                  mem_we,
  input  logic [DEPTH_LOG2-1:0] mem_waddr,
  input  logic [63:0]           mem_wdata,
  output logic                  busy,
  output logic [63:0]           burst_cnt
);
  localparam int OFF  = $clog2(BEATS * 8);
  localparam int KW   = $clog2(BEATS);
  localparam int CW   = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam int LOAD = LATENCY > 0 ? LATENCY - 1 : 0;
  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;
  state_t                state_q, state_d;
  logic [28:0]           base_q, base_d;
  logic [7:0]            len_q, len_d;
  logic [KW-1:0]         k_q, k_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rsp_ready_q, rsp_ready_d, rsp_last_q, rsp_last_d, busy_q, busy_d;
  logic [63:0]           rsp_data_q, rsp_data_d, burst_cnt_q, burst_cnt_d;
  logic [63:0]           mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  is_last;
  logic                  unused;
  assign unused    = ^{len_q, req_addr[OFF-1:0]};
  assign idx       = DEPTH_LOG2'(base_q + 29'(k_q));
  assign is_last   = k_q == KW'(BEATS - 1);
  assign rsp_ready = rsp_ready_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign busy      = busy_q;
  assign burst_cnt = burst_cnt_q;
  // Array is never reset; a same-cycle write is seen by beats one cycle later.
  always_ff @(posedge clk)
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    rsp_ready_d = 1'b0;
    rsp_last_d  = 1'b0;
    rsp_data_d  = '0;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        base_d  = {req_addr[31:OFF], KW'(0)};
        len_d   = req_len;
        k_d     = '0;
        cnt_d   = CW'(LOAD);
        state_d = LATENCY == 0 ? BURST : WAIT;
      end
      WAIT: begin
        state_d = !req_valid ? IDLE : cnt_q == '0 ? BURST : WAIT;
        cnt_d   = cnt_q - CW'(1);
      end
      BURST: if (!req_valid) state_d = IDLE;
      else begin
        rsp_ready_d = 1'b1;
        rsp_data_d  = mem[idx];
        rsp_last_d  = is_last;
        k_d         = k_q + KW'(1);
        burst_cnt_d = is_last ? burst_cnt_q + 64'd1 : burst_cnt_q;
        state_d     = is_last ? DONE : BURST;
      end
      default: state_d = req_valid ? DONE : IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      rsp_ready_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      rsp_ready_q <= rsp_ready_d;
      rsp_last_q  <= rsp_last_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      burst_cnt_q <= burst_cnt_d;
    end
endmodule
